// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch state, IF/ID payload.
// Used by the fetch stage and the decoder.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE      = 6'h00;
  localparam logic [5:0]  OP_J          = 6'h02;
  localparam logic [5:0]  FUNCT_SYSCALL = 6'h0C;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic is_jump(input logic [31:0] instr);
    return instr[31:26] == OP_J;
  endfunction

  function automatic logic is_syscall(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) && (instr[5:0] == FUNCT_SYSCALL);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC / IF/ID control priority mux for the fetch stage; purely combinational.
// Priority: branch redirect > stall hold > halt bubbles > syscall > jump > sequential.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0]  pc,
  input  logic [31:0]  inst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  fetch_state_t state,
  output logic [31:0]  pc4,
  output logic [31:0]  next_pc,
  output logic         if_id_load,
  output logic         if_id_flush,
  output fetch_state_t next_state,
  output logic         misalign_set
);

  assign pc4 = pc + 32'd4;

  always_comb begin
    next_pc      = pc;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    next_state   = state;
    misalign_set = 1'b0;
    if (branch_taken) begin
      // Redirect also cancels a speculative halt from a wrong-path SYSCALL.
      next_pc      = branch_target;
      if_id_flush  = 1'b1;
      next_state   = RUN;
      misalign_set = |branch_target[1:0];
    end else if (stall) begin
      next_pc = pc;
    end else if (state == HALT) begin
      if_id_flush = 1'b1;
    end else if (is_syscall(inst)) begin
      if_id_load = 1'b1;
      next_state = HALT;
    end else if (is_jump(inst)) begin
      if_id_load = 1'b1;
      next_pc    = {pc4[31:28], inst[25:0], 2'b00};
    end else begin
      if_id_load = 1'b1;
      next_pc    = pc4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IF/ID register, local J-type resolve, SYSCALL freeze. Latency 1 clk.
// Backpressure: stall holds PC, IF/ID and state; branch_taken overrides stall.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] read_addr,
  input  logic [31:0] inst,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err
);

  logic [31:0]  pc;
  logic [31:0]  pc4;
  logic [31:0]  next_pc;
  fetch_state_t state;
  fetch_state_t next_state;
  if_id_t       if_id;
  logic         if_id_load;
  logic         if_id_flush;
  logic         misalign_set;

  next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .inst          (inst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .state         (state),
    .pc4           (pc4),
    .next_pc       (next_pc),
    .if_id_load    (if_id_load),
    .if_id_flush   (if_id_flush),
    .next_state    (next_state),
    .misalign_set  (misalign_set)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      state        <= RUN;
      if_id        <= '0;
      misalign_err <= 1'b0;
    end else begin
      pc    <= next_pc;
      state <= next_state;
      if (if_id_flush) begin
        if_id.instr <= INSTR_NOP;
        if_id.valid <= 1'b0;
      end else if (if_id_load) begin
        if_id <= '{instr: inst, pc4: pc4, valid: 1'b1};
      end
      if (misalign_set) misalign_err <= 1'b1;
    end
  end

  assign read_addr   = pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id.valid;
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a small instruction ROM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] read_addr;
  logic [31:0] inst;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  assign inst = mem[read_addr[5:2]];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .read_addr     (read_addr),
    .inst          (inst),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .misalign_err  (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                          input logic vld);
    chk({tag, "_instr"}, if_id_instr, ins);
    chk({tag, "_pc4"}, if_id_pc4, p4);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, vld});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]  = 32'h2003_0008;
    mem[1]  = 32'h2004_0001;
    mem[2]  = 32'h0085_1020;
    mem[3]  = 32'h0000_0000;
    mem[4]  = 32'hAC03_0000;
    mem[5]  = 32'h2005_0002;
    mem[6]  = 32'h00A3_1820;
    mem[7]  = 32'h0800_0003;
    mem[9]  = 32'hAC04_0020;
    mem[10] = 32'h0000_000C;

    // Reset state
    #1 rst_n = 1'b0;
    #3;
    chk("rst_read_addr", read_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First fetch after release
    step();
    chk_ifid("first", 32'h2003_0008, 32'd4, 1'b1);
    chk("first_read_addr", read_addr, 32'd4);
    step();
    chk("seq_read_addr", read_addr, 32'd8);

    // Stall holds PC and IF/ID
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_read_addr", read_addr, 32'd8);
      chk_ifid("stall", 32'h2004_0001, 32'd8, 1'b1);
    end
    branch_taken = 1'b1;
    branch_target = 32'd12;
    step();
    chk("stallbr_read_addr", read_addr, 32'd12);
    chk_ifid("stallbr", 32'h0, 32'd8, 1'b0);
    stall = 1'b0;
    branch_taken = 1'b0;

    // Sequential run to the jump at 28
    for (int i = 0; i < 4; i++) step();
    chk("pre_jump_read_addr", read_addr, 32'd28);
    step();
    chk("jump_read_addr", read_addr, 32'd12);
    chk_ifid("jump", 32'h0800_0003, 32'd32, 1'b1);
    step();
    chk("after_jump_read_addr", read_addr, 32'd16);
    chk_ifid("after_jump", 32'h0000_0000, 32'd16, 1'b1);

    // Branch redirect at 16 -> 36
    branch_taken = 1'b1;
    branch_target = 32'd36;
    step();
    chk("br_read_addr", read_addr, 32'd36);
    chk("br_valid", {31'b0, if_id_valid}, 32'h0);
    chk("br_instr", if_id_instr, 32'h0);
    branch_taken = 1'b0;
    step();
    chk_ifid("br_target", 32'hAC04_0020, 32'd40, 1'b1);
    chk("br_next_read_addr", read_addr, 32'd40);

    // SYSCALL at 40
    step();
    chk_ifid("sys", 32'h0000_000C, 32'd44, 1'b1);
    chk("sys_halted", {31'b0, halted}, 32'h1);
    chk("sys_read_addr", read_addr, 32'd40);
    for (int i = 0; i < 11; i++) begin
      step();
      chk("halt_valid", {31'b0, if_id_valid}, 32'h0);
      chk("halt_instr", if_id_instr, 32'h0);
      chk("halt_halted", {31'b0, halted}, 32'h1);
      chk("halt_read_addr", read_addr, 32'd40);
    end
    branch_taken = 1'b1;
    branch_target = 32'd0;
    step();
    chk("unhalt_halted", {31'b0, halted}, 32'h0);
    chk("unhalt_read_addr", read_addr, 32'd0);
    chk("unhalt_valid", {31'b0, if_id_valid}, 32'h0);
    branch_taken = 1'b0;
    step();
    chk_ifid("resume", 32'h2003_0008, 32'd4, 1'b1);
    chk("resume_read_addr", read_addr, 32'd4);

    // Misaligned branch target is sticky
    chk("pre_misalign", {31'b0, misalign_err}, 32'h0);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0006;
    step();
    chk("mis_read_addr", read_addr, 32'h0000_0006);
    chk("mis_err", {31'b0, misalign_err}, 32'h1);
    branch_target = 32'd0;
    step();
    chk("mis_sticky", {31'b0, misalign_err}, 32'h1);
    chk("mis_aligned_read_addr", read_addr, 32'd0);
    branch_taken = 1'b0;
    step();
    chk("mis_seq_read_addr", read_addr, 32'd4);
    chk("mis_sticky2", {31'b0, misalign_err}, 32'h1);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_read_addr", read_addr, 32'h0);
    chk("arst_misalign", {31'b0, misalign_err}, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    chk("arst_halted", {31'b0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_resume_read_addr", read_addr, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
